pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer, used between any two core stages (EX→MEM first). It generalises the fixed-field stall-driven stage registers: the payload is one opaque `DATA_WIDTH` bus. Backpressure is carried by `in_ready`/`out_ready` instead of external stall lines. `in_ready` is registered, so there is no combinational path from `out_ready` to `in_ready`. A synchronous `flush` squashes in-flight contents on branch mispredict or exception.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: payload width in bits; must be ≥ 1.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset. Asserted when 0; all state is cleared immediately.
- `flush`  input  1  synchronous squash; highest priority after reset.
- `in_valid`  input  1  upstream has a payload.
- `in_ready`  output  1  stage can accept; registered.
- `in_data`  input  `DATA_WIDTH`  upstream payload.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  downstream accepts.
- `out_data`  output  `DATA_WIDTH`  payload to downstream; driven from the main register.
- `occupancy`  output  2  entries held: 0, 1 or 2.

## Operation
- Handshake events:
  - accept = `in_valid & in_ready`.
  - emit = `out_valid & out_ready`.
- Storage: a main register (drives `out_data`) and a skid register.
- `in_valid` may drop without an accept. Data is captured only on accept.
- States, encoded by `occupancy`:
  - EMPTY (0): `out_valid`=0, `in_ready`=1.
    - accept → BUSY; main ← `in_data`.
  - BUSY (1): `out_valid`=1, `in_ready`=1.
    - accept & emit → BUSY; main ← `in_data`.
    - accept & !emit → FULL; skid ← `in_data`; main holds.
    - !accept & emit → EMPTY; main holds its last value.
    - neither → BUSY, no change.
  - FULL (2): `out_valid`=1, `in_ready`=0 (accept is impossible).
    - emit → BUSY; main ← skid.
    - !emit → FULL, no change.
- Order is strictly FIFO. No payload is duplicated or dropped except by flush.
- Flush (`flush`=1 at a clock edge):
  - Next state is EMPTY.
  - Main and skid registers ← 0.
  - Any accept or emit in the same cycle is discarded: the upstream beat is lost, and downstream must ignore the beat (the core gates it with its own flush).
  - `in_ready`=1 in the following cycle.
- `out_data` when `out_valid`=0 holds the last main value, or 0 after reset/flush. Downstream must not sample it.
- `in_ready` is registered: it equals (next_state != FULL), computed at the clock edge.

## Timing
- Reset values (immediately on `rst`=0, held while low):
  - `out_valid`=0, `in_ready`=1, `occupancy`=0.
  - `out_data`=0, skid=0.
- Latency: accept at edge N → `out_valid`=1 with that payload after edge N; visible in cycle N+1.
- Throughput: one beat per cycle while `out_ready`=1, in steady BUSY.
- Backpressure: `out_ready` low for one cycle in BUSY with `in_valid`=1:
  - The stage absorbs one extra beat and goes FULL.
  - `in_ready` falls the following cycle.
- Recovery from FULL: `in_ready` returns to 1 one cycle after the first emit.
- Reset deasserting mid-stream: the stage starts EMPTY; no payload survives reset.
- Flush and reset together: reset wins; the result is identical anyway.

## Test plan
- **Reset:** hold `rst`=0, `in_valid`=1, `in_data`=0xDEAD_BEEF → `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=0. After release, first accept appears on `out_data` next cycle.
- **Streaming:** `out_ready`=1, inject 0x1..0x8 on consecutive cycles → `out_data` emits 0x1..0x8 on consecutive cycles, one cycle late; `occupancy` stays ≤1.
- **Skid fill:** stream 0xA, 0xB, 0xC with `out_ready`=0 from the cycle 0xA is valid:
  - 0xA in main, 0xB in skid, `occupancy`=2, `in_ready`=0, so 0xC is not accepted.
  - Raise `out_ready` → emits 0xA, 0xB, then 0xC once accepted, in order.
- **Random handshake:** random `in_valid`/`out_ready` over 10k cycles against a scoreboard queue → exact order and count match. `in_ready`=0 only when `occupancy`=2.
- **Flush:** FULL with 0x11/0x22 plus `in_valid`=1 with 0x33, pulse `flush` for one cycle:
  - Next cycle: `out_valid`=0, `occupancy`=0, `in_ready`=1, `out_data`=0.
  - 0x11, 0x22, 0x33 are never emitted.
- **Async reset mid-operation:** drop `rst` asynchronously between edges while FULL → outputs return to reset values before the next edge.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with a two-entry skid buffer.
// in_ready is registered so out_ready never reaches it combinationally.
module pipe_skid_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] main_reg, main_nxt;
   logic [DATA_WIDTH-1:0] skid_reg, skid_nxt;
   logic                  in_ready_reg;
   logic                  accept, emit;

   assign out_valid = (state != EMPTY);
   assign in_ready  = in_ready_reg;
   assign out_data  = main_reg;
   assign occupancy = state;
   assign accept    = in_valid & in_ready_reg;
   assign emit      = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= EMPTY;
         main_reg     <= '0;
         skid_reg     <= '0;
         in_ready_reg <= 1'b1;
      end else begin
         state        <= state_nxt;
         main_reg     <= main_nxt;
         skid_reg     <= skid_nxt;
         in_ready_reg <= (state_nxt != FULL);
      end
   end

   always_comb begin
      state_nxt = state;
      main_nxt  = main_reg;
      skid_nxt  = skid_reg;
      if (flush) begin
         // Any accept/emit coinciding with flush is dropped.
         state_nxt = EMPTY;
         main_nxt  = '0;
         skid_nxt  = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt = BUSY;
                  main_nxt  = in_data;
               end
            end
            BUSY: begin
               if (accept && emit) begin
                  main_nxt = in_data;
               end else if (accept) begin
                  state_nxt = FULL;
                  skid_nxt  = in_data;
               end else if (emit) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (emit) begin
                  state_nxt = BUSY;
                  main_nxt  = skid_reg;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: vector table, corner-case sequences and a
// scoreboard queue fed on accept and drained on emit.
module tb_pipe_skid_stage;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] sb[$];

   typedef struct {
      logic         iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         fl;
      logic         ev;
      logic         eir;
      logic [1:0]   eocc;
      logic [W-1:0] eod;
   } vec_t;

   vec_t vecs[$];

   pipe_skid_stage #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(logic iv, logic [W-1:0] d, logic ordy, logic fl,
                               logic ev, logic eir, logic [1:0] eocc, logic [W-1:0] eod);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
      v.ev = ev; v.eir = eir; v.eocc = eocc; v.eod = eod;
      return v;
   endfunction

   // Inputs are set just after a rising edge, so they are stable here.
   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
      end else if (flush) begin
         sb.delete();
      end else begin
         chk("inv_ready", {31'd0, in_ready}, {31'd0, occupancy != 2'd2});
         chk("inv_valid", {31'd0, out_valid}, {31'd0, occupancy != 2'd0});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", out_data, 32'hxxxx_xxxx);
            end else begin
               chk("sb_data", out_data, sb.pop_front());
            end
         end
         if (in_valid && in_ready) sb.push_back(in_data);
      end
   end

   task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with an offered beat
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      in_valid = 1'b0;
      rst = 1'b1;
      step(1'b1, 32'h0000_005A, 1'b1, 1'b0);
      chk("first_valid", {31'd0, out_valid}, 32'd1);
      chk("first_data", out_data, 32'h5A);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("first_drain", {30'd0, occupancy}, 32'd0);

      // Streaming 1..8
      for (int i = 1; i <= 8; i++)
         vecs.push_back(mk(1'b1, i, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, i));
      vecs.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'd8));
      // Skid fill A/B/C
      vecs.push_back(mk(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA));
      vecs.push_back(mk(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA));
      vecs.push_back(mk(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA));
      vecs.push_back(mk(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hB));
      vecs.push_back(mk(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hC));
      vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'hC));
      // Flush while FULL with a third beat offered
      vecs.push_back(mk(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11));
      vecs.push_back(mk(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11));
      vecs.push_back(mk(1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0));
      vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0));

      foreach (vecs[i]) begin
         step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
         chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
         chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].eir});
         chk($sformatf("vec%0d_occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].eocc});
         chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].eod);
      end

      // Asynchronous reset while FULL, between edges
      step(1'b1, 32'h77, 1'b0, 1'b0);
      step(1'b1, 32'h88, 1'b0, 1'b0);
      chk("pre_arst_occ", {30'd0, occupancy}, 32'd2);
      @(negedge clk);
      #2;
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_occupancy", {30'd0, occupancy}, 32'd0);
      chk("arst_out_data", out_data, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // Random handshake against the scoreboard
      for (int n = 0; n < 10000; n++) begin
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 63) == 0));
      end
      for (int n = 0; n < 4; n++) step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("drain_sb_empty", sb.size(), 32'd0);
      chk("drain_occupancy", {30'd0, occupancy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
